spike_packet_accumulator: RTL
=============================

Name: spike_packet_accumulator

Overview:
- Sits directly downstream of the network interface and consumes its 24-bit spike packets {source_addr[23:12], dest_addr[11:0]}.
- Buffers incoming packets in a small FIFO and keeps only those addressed to its local neuron cluster.
- For each kept packet, searches that neuron's synapse table for the source address and adds the matching signed weight into the neuron's per-timestep input accumulator.
- The accumulators feed the neuron (adder/LIF) stage.

Parameters:
- NUM_NEURONS, 10, local neurons in the cluster.
- NUM_SLOTS, 8, synapse-table entries per neuron.
- ADDR_W, 12, neuron address width.
- BASE_ADDR, 12'h010, address of local neuron 0; local range is BASE_ADDR .. BASE_ADDR+NUM_NEURONS-1.
- WEIGHT_W, 16, signed weight width.
- ACC_W, 24, signed accumulator width.
- FIFO_DEPTH, 4, input buffer depth (power of 2).

Ports:
- CLK  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- clear  in  1  synchronous timestep-start pulse.
- pkt_valid  in  1  packet offered.
- pkt_ready  out  1  FIFO can accept.
- packet  in  2*ADDR_W  {src, dest}.
- wt_we  in  1  synapse-table write strobe.
- wt_neuron  in  4  local neuron index.
- wt_slot  in  3  slot index.
- wt_src  in  ADDR_W  source address for the entry.
- wt_value  in  WEIGHT_W  signed weight.
- acc_sel  in  4  accumulator read index.
- acc_data  out  ACC_W  accumulator[acc_sel], combinational read.
- busy  out  1  FSM not IDLE, or FIFO not empty.
- miss_count  out  8  dropped packets this timestep (saturates at 255).

Behaviour:
- Reset:
  - All accumulators 0, FIFO empty, FSM IDLE, miss_count 0.
  - All table entries invalid.
  - pkt_ready 0 during reset, 1 after.
- Handshake:
  - Push on a CLK edge where pkt_valid && pkt_ready.
  - pkt_ready = !fifo_full && !clear.
  - A push and a pop in the same cycle are allowed; occupancy is unchanged.
- FSM states: IDLE, SEARCH, ACCUM.
  - IDLE with FIFO non-empty: pop and latch cur_src / cur_dest.
    - Dest outside the local range: increment miss_count, stay IDLE.
    - Dest in range: set idx = dest - BASE_ADDR, slot = 0, go to SEARCH.
  - SEARCH: compare one slot per cycle. The entry matches when it is valid and its src equals cur_src.
    - Match: latch the weight, go to ACCUM.
    - No match and slot == NUM_SLOTS-1: increment miss_count, go to IDLE.
    - Otherwise slot + 1.
  - ACCUM: acc[idx] <= acc[idx] + sign-extended weight, go to IDLE.
- Latency: a packet pushed at edge E0 and matching slot k updates acc at edge E0 + 3 + k, when the FIFO is otherwise empty. Packets are processed strictly in FIFO order.
- Table write:
  - Takes effect at the edge and sets the entry valid.
  - A SEARCH comparing the same slot in that cycle uses the old contents.
  - Writes are accepted in every state.
- Duplicate src in two slots: the lowest slot wins.
- clear:
  - Has priority over all activity except reset.
  - Zeroes accumulators and miss_count, flushes the FIFO, forces IDLE.
  - Any in-flight packet is discarded.
  - The synapse table is retained.
- reset mid-operation: same as clear, and additionally invalidates the table.

Optional Feature:
- Macro: ACC_SATURATE_EN.
- Defined: the ACCUM add saturates to the signed ACC_W maximum/minimum.
- Undefined: two's-complement wrap.
- miss_count saturates in both builds.

Decomposition:
- Package snn_noc_pkg holds:
  - ADDR_W and PKT_W = 2*ADDR_W.
  - Packet field slice constants (SRC_MSB/LSB, DEST_MSB/LSB).
  - The FSM state enum.
  - The default WEIGHT_W.
- One natural sub-module: packet_fifo, a synchronous FIFO with push/pop, full/empty and flush.

Test Plan:
1. Write neuron 2 / slot 0 = {src 12'h005, w +100}. Send packet {12'h005, 12'h012} → acc_data (acc_sel=2) = 100 at E0+3; miss_count = 0; busy low afterwards.
2. Write neuron 0 / slot 7 = {12'h0A0, w -3}. Send {12'h0A0, 12'h010} → acc[0] = -3 at E0+10. Send the same packet again → acc[0] = -6.
3. Send {12'h005, 12'h030} (non-local) → miss_count = 1 and all acc unchanged. Send {12'h0FF, 12'h012} (no table match) → miss_count = 2 after the 8-slot search.
4. Hold pkt_valid for 6 back-to-back slot-7-matching packets → pkt_ready drops while 4 are buffered; no packet lost; acc[0] = 6 × (-3) = -18.
5. Override ACC_W=16; two packets with w = 16'h7FFF → acc = 16'h7FFF with ACC_SATURATE_EN, 16'hFFFE without.
6. Pulse clear while in SEARCH with 2 packets buffered → next cycle all acc = 0, miss_count = 0, FIFO empty, IDLE. A following test-1 packet yields acc[2] = 100, proving the table was retained.

Source files
------------

// File: rtl/snn_noc_pkg.sv
// rtl/snn_noc_pkg.sv - packet layout, widths and FSM states shared by the spike accumulator
package snn_noc_pkg;
   localparam int ADDR_W       = 12;
   localparam int PKT_W        = 2 * ADDR_W;
   localparam int SRC_MSB      = PKT_W - 1;
   localparam int SRC_LSB      = ADDR_W;
   localparam int DEST_MSB     = ADDR_W - 1;
   localparam int DEST_LSB     = 0;
   localparam int DEF_WEIGHT_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SEARCH = 2'd1,
      ST_ACCUM  = 2'd2
   } state_t;
endpackage

// File: rtl/packet_fifo.sv
// rtl/packet_fifo.sv - synchronous FIFO with flush; pointers carry an extra wrap bit for full/empty
module packet_fifo #(
   parameter int W     = 24,
   parameter int DEPTH = 4
) (
   input  logic         i_clk,
   input  logic         i_reset,
   input  logic         i_flush,
   input  logic         i_push,
   input  logic [W-1:0] i_push_data,
   input  logic         i_pop,
   output logic [W-1:0] o_pop_data,
   output logic         o_full,
   output logic         o_empty
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] r_mem [DEPTH];
   logic [AW:0]  r_wr;
   logic [AW:0]  r_rd;
   logic         w_push;
   logic         w_pop;

   assign w_push     = i_push && !o_full;
   assign w_pop      = i_pop && !o_empty;
   assign o_empty    = (r_wr == r_rd);
   assign o_full     = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
   assign o_pop_data = r_mem[r_rd[AW-1:0]];

   always_ff @(posedge i_clk) begin
      if (i_reset || i_flush) begin
         r_wr <= '0;
         r_rd <= '0;
      end else begin
         if (w_push) r_wr <= r_wr + (AW+1)'(1);
         if (w_pop)  r_rd <= r_rd + (AW+1)'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wr[AW-1:0]] <= i_push_data;
   end
endmodule

// File: rtl/spike_packet_accumulator.sv
// rtl/spike_packet_accumulator.sv - filters local spike packets, looks up synapse weights, accumulates per neuron
// ACC_SATURATE_EN: saturating accumulator add instead of two's-complement wrap.
module spike_packet_accumulator
   import snn_noc_pkg::*;
#(
   parameter int                NUM_NEURONS = 10,
   parameter int                NUM_SLOTS   = 8,
   parameter logic [ADDR_W-1:0] BASE_ADDR   = 12'h010,
   parameter int                WEIGHT_W    = DEF_WEIGHT_W,
   parameter int                ACC_W       = 24,
   parameter int                FIFO_DEPTH  = 4
) (
   input  logic                CLK,
   input  logic                reset,
   input  logic                clear,
   input  logic                pkt_valid,
   output logic                pkt_ready,
   input  logic [PKT_W-1:0]    packet,
   input  logic                wt_we,
   input  logic [3:0]          wt_neuron,
   input  logic [2:0]          wt_slot,
   input  logic [ADDR_W-1:0]   wt_src,
   input  logic [WEIGHT_W-1:0] wt_value,
   input  logic [3:0]          acc_sel,
   output logic [ACC_W-1:0]    acc_data,
   output logic                busy,
   output logic [7:0]          miss_count
);
   localparam int IDX_W  = $clog2(NUM_NEURONS);
   localparam int SLOT_W = $clog2(NUM_SLOTS);

   state_t                     r_state;
   state_t                     w_next;
   logic                       r_tbl_valid [NUM_NEURONS][NUM_SLOTS];
   logic [ADDR_W-1:0]          r_tbl_src   [NUM_NEURONS][NUM_SLOTS];
   logic signed [WEIGHT_W-1:0] r_tbl_wt    [NUM_NEURONS][NUM_SLOTS];
   logic signed [ACC_W-1:0]    r_acc       [NUM_NEURONS];
   logic [ADDR_W-1:0]          r_cur_src;
   logic [IDX_W-1:0]           r_idx;
   logic [SLOT_W-1:0]          r_slot;
   logic signed [WEIGHT_W-1:0] r_wt;
   logic [7:0]                 r_miss;

   logic                       w_push;
   logic                       w_pop;
   logic                       w_full;
   logic                       w_empty;
   logic [PKT_W-1:0]           w_head;
   logic [ADDR_W-1:0]          w_dest;
   logic [ADDR_W-1:0]          w_dest_off;
   logic                       w_in_range;
   logic                       w_match;
   logic                       w_slot_inc;
   logic                       w_load_wt;
   logic                       w_acc_en;
   logic                       w_miss_inc;
   logic                       w_wt_ok;
   logic signed [ACC_W-1:0]    w_acc_next;

   assign pkt_ready  = !reset && !clear && !w_full;
   assign w_push     = pkt_valid && pkt_ready;
   assign busy       = (r_state != ST_IDLE) || !w_empty;
   assign miss_count = r_miss;

   packet_fifo #(.W(PKT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .i_clk       (CLK),
      .i_reset     (reset),
      .i_flush     (clear),
      .i_push      (w_push),
      .i_push_data (packet),
      .i_pop       (w_pop),
      .o_pop_data  (w_head),
      .o_full      (w_full),
      .o_empty     (w_empty)
   );

   assign w_dest     = w_head[DEST_MSB:DEST_LSB];
   assign w_dest_off = w_dest - BASE_ADDR;
   assign w_in_range = (w_dest >= BASE_ADDR) && (32'(w_dest_off) < NUM_NEURONS);
   assign w_match    = r_tbl_valid[r_idx][r_slot] && (r_tbl_src[r_idx][r_slot] == r_cur_src);
   assign w_wt_ok    = (32'(wt_neuron) < NUM_NEURONS) && (32'(wt_slot) < NUM_SLOTS);

   always_comb begin
      acc_data = '0;
      if (32'(acc_sel) < NUM_NEURONS) acc_data = r_acc[acc_sel];
   end

`ifdef ACC_SATURATE_EN
   logic signed [ACC_W:0] w_sum;
   always_comb begin
      w_sum = (ACC_W+1)'(r_acc[r_idx]) + (ACC_W+1)'(r_wt);
      if (w_sum[ACC_W] != w_sum[ACC_W-1])
         w_acc_next = w_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      else
         w_acc_next = w_sum[ACC_W-1:0];
   end
`else
   always_comb begin
      w_acc_next = r_acc[r_idx] + ACC_W'(r_wt);
   end
`endif

   always_ff @(posedge CLK) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next     = r_state;
      w_pop      = 1'b0;
      w_slot_inc = 1'b0;
      w_load_wt  = 1'b0;
      w_acc_en   = 1'b0;
      w_miss_inc = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (!w_empty) begin
               w_pop = 1'b1;
               if (w_in_range) w_next = ST_SEARCH;
               else            w_miss_inc = 1'b1;
            end
         end
         ST_SEARCH: begin
            if (w_match) begin
               w_load_wt = 1'b1;
               w_next    = ST_ACCUM;
            end else if (r_slot == SLOT_W'(NUM_SLOTS - 1)) begin
               w_miss_inc = 1'b1;
               w_next     = ST_IDLE;
            end else begin
               w_slot_inc = 1'b1;
            end
         end
         ST_ACCUM: begin
            w_acc_en = 1'b1;
            w_next   = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
      // clear drops whatever packet is in flight
      if (clear) begin
         w_next     = ST_IDLE;
         w_pop      = 1'b0;
         w_slot_inc = 1'b0;
         w_load_wt  = 1'b0;
         w_acc_en   = 1'b0;
         w_miss_inc = 1'b0;
      end
   end

   always_ff @(posedge CLK) begin
      if (reset || clear) begin
         for (int n = 0; n < NUM_NEURONS; n++) r_acc[n] <= '0;
         r_miss <= '0;
      end else begin
         if (w_acc_en) r_acc[r_idx] <= w_acc_next;
         if (w_miss_inc && (r_miss != 8'hFF)) r_miss <= r_miss + 8'd1;
      end
   end

   always_ff @(posedge CLK) begin
      if (w_pop) begin
         r_cur_src <= w_head[SRC_MSB:SRC_LSB];
         r_idx     <= w_dest_off[IDX_W-1:0];
         r_slot    <= '0;
      end else if (w_slot_inc) begin
         r_slot <= r_slot + SLOT_W'(1);
      end
      if (w_load_wt) r_wt <= r_tbl_wt[r_idx][r_slot];
   end

   // only the valid bits need resetting; src/weight are qualified by them
   always_ff @(posedge CLK) begin
      if (reset) begin
         for (int n = 0; n < NUM_NEURONS; n++)
            for (int s = 0; s < NUM_SLOTS; s++)
               r_tbl_valid[n][s] <= 1'b0;
      end else if (wt_we && w_wt_ok) begin
         r_tbl_valid[wt_neuron][wt_slot] <= 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (wt_we && w_wt_ok) begin
         r_tbl_src[wt_neuron][wt_slot] <= wt_src;
         r_tbl_wt[wt_neuron][wt_slot]  <= wt_value;
      end
   end
endmodule
